// File: rtl/count_display_driver.sv
// Binary-to-decimal display driver: sequential double-dabble conversion feeding a
// multiplexed three-digit common-anode seven-segment scan. Optional: LEADING_ZERO_BLANK_EN.
module count_display_driver #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic [7:0]  value_in,
    output logic [6:0]  seg_out,
    output logic [2:0]  an_out,
    output logic [11:0] bcd_out,
    output logic        busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

    logic [1:0]    state_q;
    logic [7:0]    last_val_q;
    logic [7:0]    shift_q;
    logic [11:0]   scratch_q;
    logic [2:0]    bit_cnt_q;
    logic [11:0]   adj;
    logic [19:0]   dd_next;
    logic [PW-1:0] presc_q;
    logic [1:0]    digit_q;
    logic [3:0]    nibble;
    logic          blank;
    logic [2:0]    an_next;
    logic [6:0]    seg_next;

    // Add-3 correction on each BCD nibble, then shift scratch and binary together.
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < 3; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
        dd_next = {adj, shift_q} << 1;
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            last_val_q <= 8'd0;
            shift_q    <= 8'd0;
            scratch_q  <= 12'd0;
            bit_cnt_q  <= 3'd0;
            bcd_out    <= 12'h000;
            busy       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (value_in != last_val_q) begin
                        shift_q    <= value_in;
                        last_val_q <= value_in;
                        scratch_q  <= 12'd0;
                        bit_cnt_q  <= 3'd0;
                        busy       <= 1'b1;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    {scratch_q, shift_q} <= dd_next;
                    bit_cnt_q            <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    bcd_out <= scratch_q;
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            digit_q <= 2'd0;
        end else if (presc_q == PRESC_MAX) begin
            presc_q <= '0;
            digit_q <= (digit_q == 2'd2) ? 2'd0 : digit_q + 2'd1;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    always_comb begin
        case (digit_q)
            2'd0:    begin nibble = bcd_out[3:0];  an_next = 3'b110; end
            2'd1:    begin nibble = bcd_out[7:4];  an_next = 3'b101; end
            default: begin nibble = bcd_out[11:8]; an_next = 3'b011; end
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        blank = ((digit_q == 2'd2) && (bcd_out[11:8] == 4'd0)) ||
                ((digit_q == 2'd1) && (bcd_out[11:4] == 8'd0));
`else
        blank = 1'b0;
`endif
        case (nibble)
            4'd0:    seg_next = 7'b1000000;
            4'd1:    seg_next = 7'b1111001;
            4'd2:    seg_next = 7'b0100100;
            4'd3:    seg_next = 7'b0110000;
            4'd4:    seg_next = 7'b0011001;
            4'd5:    seg_next = 7'b0010010;
            4'd6:    seg_next = 7'b0000010;
            4'd7:    seg_next = 7'b1111000;
            4'd8:    seg_next = 7'b0000000;
            4'd9:    seg_next = 7'b0010000;
            default: seg_next = 7'b1111111;
        endcase
        if (blank) begin
            seg_next = 7'b1111111;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            an_out  <= 3'b110;
            seg_out <= 7'b1000000;
        end else begin
            an_out  <= an_next;
            seg_out <= seg_next;
        end
    end

endmodule
